pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/mips_pipe_pkg.sv | 42 ++++
 rtl/pipeline_stall_ctrl_if.sv | 49 ++++
 rtl/pipeline_stall_ctrl_stall_counter.sv | 25 ++
 rtl/pipeline_stall_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings and control-word helpers for the pipeline stall controller.
package mips_pipe_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_STALL   = 2'd1;
  localparam logic [1:0] ST_MD_WAIT = 2'd2;

  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic md_busy;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
          if_id_flush: 1'b0, id_ex_flush: 1'b0, md_busy: 1'b0};
    return c;
  endfunction

  // Bubble into EX while PC and IF/ID hold.
  function automatic ctrl_t ctrl_stall();
    ctrl_t c;
    c = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
          if_id_flush: 1'b0, id_ex_flush: 1'b1, md_busy: 1'b0};
    return c;
  endfunction

  // Whole front end frozen while the multiply/divide unit works.
  function automatic ctrl_t ctrl_md_hold();
    ctrl_t c;
    c = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
          if_id_flush: 1'b0, id_ex_flush: 1'b0, md_busy: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the stall controller.
// Counter signals exist only when STALL_CNT_EN is defined.
interface pipeline_stall_ctrl_if;
  import mips_pipe_pkg::*;

  logic hz_load_use;
  logic hz_branch_ex;
  logic hz_branch_ex_load;
  logic hz_branch_mem;
  logic branch_taken;
  logic md_start;
  logic md_done;
  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic md_busy;
`ifdef STALL_CNT_EN
  logic                   stall_cnt_clr;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output hz_load_use, hz_branch_ex, hz_branch_ex_load, hz_branch_mem,
           branch_taken, md_start, md_done, stall_cnt_clr,
    input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
           md_busy, stall_count
  );
  modport slave (
    input  hz_load_use, hz_branch_ex, hz_branch_ex_load, hz_branch_mem,
           branch_taken, md_start, md_done, stall_cnt_clr,
    output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
           md_busy, stall_count
  );
`else
  modport master (
    output hz_load_use, hz_branch_ex, hz_branch_ex_load, hz_branch_mem,
           branch_taken, md_start, md_done,
    input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
           md_busy
  );
  modport slave (
    input  hz_load_use, hz_branch_ex, hz_branch_ex_load, hz_branch_mem,
           branch_taken, md_start, md_done,
    output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
           md_busy
  );
`endif
endinterface

// File: rtl/pipeline_stall_ctrl_stall_counter.sv
// Saturating stall-cycle counter; clear has priority over increment.
module stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline (RUN / STALL / MD_WAIT).
// Define STALL_CNT_EN to add the saturating stall_count with stall_cnt_clr.
module pipeline_stall_ctrl
  import mips_pipe_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  ctrl_t      w_ctrl;
  logic       w_hazard;

  assign w_hazard = bus.hz_load_use | bus.hz_branch_ex | bus.hz_branch_mem |
                    bus.hz_branch_ex_load;

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_ctrl      = ctrl_idle();
    w_state_nxt = r_state;
    if (reset) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.md_start) begin
            // A same-cycle md_done is a single-cycle op: stay idle.
            if (!bus.md_done) begin
              w_ctrl      = ctrl_md_hold();
              w_state_nxt = ST_MD_WAIT;
            end
          end else if (w_hazard) begin
            w_ctrl = ctrl_stall();
            if (bus.hz_branch_ex_load) w_state_nxt = ST_STALL;
          end else if (bus.branch_taken) begin
            w_ctrl.if_id_flush = 1'b1;
          end
        end
        ST_STALL: begin
          w_ctrl      = ctrl_stall();
          w_state_nxt = ST_RUN;
        end
        ST_MD_WAIT: begin
          if (bus.md_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl = ctrl_md_hold();
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  assign bus.pc_write    = w_ctrl.pc_write;
  assign bus.if_id_write = w_ctrl.if_id_write;
  assign bus.id_ex_write = w_ctrl.id_ex_write;
  assign bus.if_id_flush = w_ctrl.if_id_flush;
  assign bus.id_ex_flush = w_ctrl.id_ex_flush;
  assign bus.md_busy     = w_ctrl.md_busy;

`ifdef STALL_CNT_EN
  logic [STALL_CNT_W-1:0] w_stall_count;

  stall_counter #(.W(STALL_CNT_W)) u_stall_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (bus.stall_cnt_clr),
    .i_inc   (~w_ctrl.pc_write),
    .o_count (w_stall_count)
  );

  assign bus.stall_count = w_stall_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl against a behavioural model.
// Counter checks are compiled in when STALL_CNT_EN is defined.
module tb_pipeline_stall_ctrl;
  import mips_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if bus();

  pipeline_stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: outstanding forced stall cycles, waiting-on-divider flag, stall count.
  int m_extra = 0;
  bit m_md    = 1'b0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bits: {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, md_busy}
  localparam logic [5:0] E_IDLE  = 6'b111000;
  localparam logic [5:0] E_STALL = 6'b001010;
  localparam logic [5:0] E_HOLD  = 6'b000001;
  localparam logic [5:0] E_FLUSH = 6'b111100;

  function automatic logic [5:0] model_out();
    if (reset)   return E_IDLE;
    if (m_md)    return bus.md_done ? E_IDLE : E_HOLD;
    if (m_extra > 0) return E_STALL;
    if (bus.md_start) return bus.md_done ? E_IDLE : E_HOLD;
    if (bus.hz_load_use || bus.hz_branch_ex || bus.hz_branch_mem || bus.hz_branch_ex_load)
      return E_STALL;
    if (bus.branch_taken) return E_FLUSH;
    return E_IDLE;
  endfunction

  task automatic drive(input bit lu, input bit bex, input bit bexl, input bit bmem,
                       input bit bt, input bit ms, input bit md);
    bus.hz_load_use       = lu;
    bus.hz_branch_ex      = bex;
    bus.hz_branch_ex_load = bexl;
    bus.hz_branch_mem     = bmem;
    bus.branch_taken      = bt;
    bus.md_start          = ms;
    bus.md_done           = md;
  endtask

  task automatic set_clr(input bit c);
`ifdef STALL_CNT_EN
    bus.stall_cnt_clr = c;
`else
    if (c) begin end
`endif
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic step(input string tag);
    logic [5:0] exp;
    logic [5:0] obs;
    bit         clr;
    exp = model_out();
    @(negedge clk);
    obs = {bus.pc_write, bus.if_id_write, bus.id_ex_write,
           bus.if_id_flush, bus.id_ex_flush, bus.md_busy};
    check(tag, 32'(obs), 32'(exp));
`ifdef STALL_CNT_EN
    check({tag, "_cnt"}, 32'(bus.stall_count), 32'(m_cnt));
    clr = bus.stall_cnt_clr;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    if (reset) begin
      m_md = 1'b0; m_extra = 0; m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (!exp[5] && m_cnt < 65535) m_cnt++;
      if (m_md)              m_md = !bus.md_done;
      else if (m_extra > 0)  m_extra--;
      else if (bus.md_start) m_md = !bus.md_done;
      else if (bus.hz_branch_ex_load) m_extra = 1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    set_clr(0);
    step("reset0");
    drive(1, 1, 1, 1, 1, 1, 0);   // everything ignored under reset
    step("reset_ignore");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step("idle");

    // Load-use: one stall cycle, then idle.
    drive(1, 0, 0, 0, 0, 0, 0); step("lu_stall");
    drive(0, 0, 0, 0, 0, 0, 0); step("lu_after");
    step("lu_after2");

    // Branch on load in EX: two stall cycles, second regardless of inputs.
    drive(0, 0, 1, 0, 0, 0, 0); step("bexl_1");
    drive(0, 0, 0, 0, 1, 1, 0); step("bexl_2");
    drive(0, 0, 0, 0, 0, 0, 0); step("bexl_idle");

    // Multiply/divide: busy for 5 cycles, hazards ignored while waiting.
    drive(0, 0, 0, 0, 0, 1, 0); step("md_start");
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0); step("md_wait");
    end
    drive(1, 0, 0, 0, 0, 0, 1); step("md_done");
    drive(0, 0, 0, 0, 0, 1, 1); step("md_single");
    drive(0, 0, 0, 0, 0, 0, 1); step("md_done_run");

    // Branch taken under hazard is not flushed; alone it is.
    drive(0, 0, 0, 1, 1, 0, 0); step("bt_hz");
    drive(0, 0, 0, 0, 1, 0, 0); step("bt_flush");
    drive(0, 1, 0, 0, 1, 0, 0); step("bex_stall");

    // Reset in the middle of MD_WAIT.
    drive(0, 0, 0, 0, 0, 1, 0); step("md_start2");
    drive(0, 0, 0, 0, 0, 0, 0); step("md_wait2");
    reset = 1'b1; step("md_reset");
    reset = 1'b0; step("after_reset");

`ifdef STALL_CNT_EN
    // Clear beats increment.
    drive(1, 0, 0, 0, 0, 0, 0); step("cnt_inc");
    set_clr(1); step("cnt_clr_stall");
    set_clr(0); drive(0, 0, 0, 0, 0, 0, 0); step("cnt_after_clr");
    // Saturation.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step("sat");
    drive(0, 0, 0, 0, 0, 0, 0); step("sat_hold");
    check("sat_final", 32'(bus.stall_count), 32'hFFFF);
    set_clr(1); step("sat_clr");
    set_clr(0); step("sat_cleared");
`endif

    // Randomized traffic with occasional reset and clear.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0);
      set_clr($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
